// File: rtl/router_arb_pkg.sv
// Shared parameters and types for the router arbiter.
// Defaults, tag width and the grant FSM state encoding.
package router_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 32;
  localparam int MAX_OUT_DEF = 8;
  localparam int TAG_W       = $clog2(NUM_REQ_DEF);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

endpackage

// File: rtl/router_arbiter_tag_fifo.sv
// In-order tag FIFO recording the owner of every beat in flight.
// Depth is a power of two so pointers wrap naturally.
module tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wr_data,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_arbiter.sv
// Packet-granular round-robin arbiter in front of a shared
// datapath, routing each result back to the beat's owner.
module router_arbiter
  import router_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         data_rt_in,
  output logic                     data_in_rt_valid,
  input  logic [WIDTH-1:0]         data_rt_out,
  input  logic                     data_out_rt_valid,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     err_unexpected
);

  localparam int TW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_OUT) + 1;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] grant;
  logic [TW-1:0] grant_nx;
  logic [TW-1:0] rr_ptr;
  logic [TW-1:0] rr_nx;
  logic [TW-1:0] pick;
  logic          found;

  logic [TW-1:0] head;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          room;
  logic          accept;
  logic          pop;
  logic [WIDTH-1:0]   beat;
  logic [NUM_REQ-1:0] head_oh;

  assign room    = (count < CW'(MAX_OUT));
  assign accept  = (state == BUSY) & req_valid[grant] & room;
  assign pop     = data_out_rt_valid & ~empty;
  assign beat    = req_data[grant*WIDTH +: WIDTH];
  assign head_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << head;

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid[k]) begin
        pick  = TW'(k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == BUSY) begin
      req_ready[grant] = room;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      rr_ptr <= rr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    rr_nx    = rr_ptr;
    unique case (state)
      IDLE: begin
        if (found && !full) begin
          grant_nx = pick;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (accept && req_last[grant]) begin
          state_nx = IDLE;
          rr_nx    = (grant == TW'(NUM_REQ - 1))
                   ? '0 : grant + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_rt_in       <= '0;
      data_in_rt_valid <= 1'b0;
      rsp_valid        <= '0;
      rsp_data         <= '0;
      err_unexpected   <= 1'b0;
    end else begin
      data_in_rt_valid <= accept;
      if (accept) begin
        data_rt_in <= beat;
      end
      rsp_valid <= pop ? head_oh : '0;
      if (pop) begin
        rsp_data <= data_rt_out;
      end
      if (data_out_rt_valid && empty) begin
        err_unexpected <= 1'b1;
      end
    end
  end

  tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (TW)
  ) u_tags (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .pop     (pop),
    .wr_data (grant),
    .rd_data (head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

endmodule

// File: tb/tb_router_arbiter.sv
// Randomized and directed bench for router_arbiter against a
// queue-based packet/tag reference model.
module tb_router_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int M = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   data_rt_in;
  logic           data_in_rt_valid;
  logic [W-1:0]   data_rt_out;
  logic           data_out_rt_valid;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           err_unexpected;

  always #5 clk = ~clk;

  router_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W),
    .MAX_OUT (M)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_last          (req_last),
    .req_ready         (req_ready),
    .data_rt_in        (data_rt_in),
    .data_in_rt_valid  (data_in_rt_valid),
    .data_rt_out       (data_rt_out),
    .data_out_rt_valid (data_out_rt_valid),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .err_unexpected    (err_unexpected)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: packet owner, rr pointer, tag queue.
  bit           m_busy = 0;
  int           m_g    = 0;
  int           m_rr   = 0;
  int           m_q[$];
  bit           m_err  = 0;
  bit           m_iv   = 0;
  logic [W-1:0] m_id   = '0;
  logic [N-1:0] m_rv   = '0;
  logic [W-1:0] m_rd   = '0;

  bit           echo = 0;
  bit           p_v[2];
  logic [W-1:0] p_d[2];
  logic [W-1:0] seen_in[$];
  logic [W-1:0] seen_rsp[$];
  logic [N-1:0] seen_rv[$];

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] one;
    one = 1;
    if (m_busy && m_q.size() < M) return one << m_g;
    return '0;
  endfunction

  task automatic model_edge();
    int sz;
    bit acc;
    bit was_busy;
    logic [N-1:0] one;
    one = 1;
    sz = m_q.size();
    was_busy = m_busy;
    if (reset) begin
      m_busy = 0; m_g = 0; m_rr = 0; m_q.delete();
      m_err = 0; m_iv = 0; m_id = '0;
      m_rv = '0; m_rd = '0;
      return;
    end
    acc = was_busy && req_valid[m_g] && sz < M;
    m_rv = '0;
    if (data_out_rt_valid) begin
      if (sz > 0) begin
        m_rv = one << m_q[0];
        m_rd = data_rt_out;
        void'(m_q.pop_front());
      end else begin
        m_err = 1;
      end
    end
    m_iv = acc;
    if (acc) begin
      m_id = req_data[m_g*W +: W];
      m_q.push_back(m_g);
      if (req_last[m_g]) begin
        m_busy = 0;
        m_rr = (m_g + 1) % N;
      end
    end
    if (!was_busy && req_valid != 0 && sz < M) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (req_valid[k]) begin
          m_g = k;
          break;
        end
      end
      m_busy = 1;
    end
  endtask

  task automatic step();
    chk("req_ready", req_ready, m_ready());
    @(posedge clk);
    model_edge();
    #1;
    chk("in_valid", data_in_rt_valid, m_iv);
    chk("in_data", data_rt_in, m_id);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_data", rsp_data, m_rd);
    chk("err", err_unexpected, m_err);
    if (data_in_rt_valid) seen_in.push_back(data_rt_in);
    if (rsp_valid != 0) begin
      seen_rsp.push_back(rsp_data);
      seen_rv.push_back(rsp_valid);
    end
    if (echo) begin
      data_out_rt_valid = p_v[1];
      data_rt_out = p_d[1];
      p_v[1] = p_v[0];
      p_d[1] = p_d[0];
      p_v[0] = m_iv;
      p_d[0] = m_id + 1;
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_last = '0;
    data_out_rt_valid = 0;
    data_rt_out = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    echo = 0;
    p_v[0] = 0; p_v[1] = 0;
    reset = 1;
    step();
    reset = 0;
    seen_in.delete();
    seen_rsp.delete();
    seen_rv.delete();
  endtask

  task automatic send(int r, logic [W-1:0] d, bit last);
    int t;
    bit acc;
    t = 0;
    acc = 0;
    req_valid = '0;
    req_valid[r] = 1;
    req_data[r*W +: W] = d;
    req_last = '0;
    req_last[r] = last;
    while (!acc && t < 40) begin
      acc = req_ready[r];
      step();
      t++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    req_valid = '0;
    req_last = '0;
  endtask

  initial begin
    logic [W-1:0] a;
    int acc_n;
    reset = 1;
    req_data = '0;
    idle_inputs();
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", rsp_data, 0);

    // three-beat packet through an echo datapath
    echo = 1;
    a = 32'hA1;
    for (int b = 0; b < 3; b++) send(1, a + b, b == 2);
    for (int i = 0; i < 8; i++) step();
    chk("p1_in_cnt", seen_in.size(), 3);
    chk("p1_rsp_cnt", seen_rsp.size(), 3);
    for (int i = 0; i < 3 && i < seen_rsp.size(); i++) begin
      chk("p1_rsp_d", seen_rsp[i], 32'hA2 + i);
      chk("p1_rsp_v", seen_rv[i], 4'b0010);
    end

    // round-robin over continuous single-beat packets
    do_reset();
    req_valid = '1;
    req_last = '1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = i;
    for (int i = 0; i < 10; i++) step();
    idle_inputs();
    chk("rr_cnt", seen_in.size(), 5);
    for (int i = 0; i < 5 && i < seen_in.size(); i++)
      chk("rr_order", seen_in[i], i % N);

    // in-flight limit with withheld results
    do_reset();
    req_valid[0] = 1;
    acc_n = 0;
    for (int i = 0; i < 20 && acc_n < 10; i++) begin
      req_data[W-1:0] = 32'h100 + acc_n;
      if (req_ready[0]) acc_n++;
      step();
    end
    chk("lim_acc", acc_n, M);
    chk("lim_ready", req_ready[0], 0);
    data_out_rt_valid = 1;
    data_rt_out = 32'h55;
    step();
    data_out_rt_valid = 0;
    chk("lim_ready_up", req_ready[0], 1);
    chk("lim_rsp", rsp_valid, 4'b0001);
    step();
    chk("lim_ninth", seen_in.size(), M + 1);
    idle_inputs();

    // result with nothing in flight
    do_reset();
    data_out_rt_valid = 1;
    step();
    data_out_rt_valid = 0;
    chk("unexp_err", err_unexpected, 1);
    chk("unexp_rsp", rsp_valid, 0);
    for (int i = 0; i < 3; i++) step();
    chk("unexp_sticky", err_unexpected, 1);

    // reset with beats in flight mid-packet
    do_reset();
    for (int b = 0; b < 3; b++) send(1, 32'hC0 + b, 0);
    reset = 1;
    req_valid[1] = 1;
    step();
    reset = 0;
    req_valid = '0;
    chk("rst_mid_ready", req_ready, 0);
    chk("rst_mid_in", data_rt_in, 0);
    chk("rst_mid_inv", data_in_rt_valid, 0);
    for (int i = 0; i < 3; i++) begin
      data_out_rt_valid = 1;
      step();
      chk("rst_mid_rsp", rsp_valid, 0);
    end
    data_out_rt_valid = 0;
    chk("rst_mid_err", err_unexpected, 1);

    // push and pop together at count 4
    do_reset();
    send(0, 32'hD0, 0);
    send(0, 32'hD1, 1);
    send(2, 32'hD2, 0);
    send(2, 32'hD3, 0);
    req_valid[2] = 1;
    req_data[2*W +: W] = 32'hD4;
    data_out_rt_valid = 1;
    data_rt_out = 32'hE0;
    step();
    data_out_rt_valid = 0;
    chk("pp_rsp", rsp_valid, 4'b0001);
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_ready[2]) acc_n++;
      step();
    end
    chk("pp_fill", acc_n, 4);
    idle_inputs();

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      req_last = '0;
      for (int i = 0; i < N; i++) begin
        req_last[i] = ($urandom_range(0, 2) == 0);
        req_data[i*W +: W] = $urandom;
      end
      data_out_rt_valid = ($urandom_range(0, 2) == 0);
      data_rt_out = $urandom;
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 0;
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_arbiter.md
ROUTER_ARBITER -- requirements
Module: router_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing the router datapath.
REQ-002 Parameter WIDTH, 32, data width of request and response beats.
REQ-003 Parameter MAX_OUT, 8, maximum beats in flight in the datapath; power of two.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  NUM_REQ  per-requester beat valid.
REQ-007 req_data  in  NUM_REQ x WIDTH  per-requester beat data.
REQ-008 req_last  in  NUM_REQ  marks final beat of requester's packet.
REQ-009 req_ready  out  NUM_REQ  per-requester beat accept.
REQ-010 data_rt_in  out  WIDTH  beat to datapath.
REQ-011 data_in_rt_valid  out  1  datapath input strobe.
REQ-012 data_rt_out  in  WIDTH  datapath result.
REQ-013 data_out_rt_valid  in  1  datapath result strobe; datapath has no backpressure.
REQ-014 rsp_valid  out  NUM_REQ  one-hot response strobe to owning requester.
REQ-015 rsp_data  out  WIDTH  response data, shared by all requesters.
REQ-016 err_unexpected  out  1  sticky: result arrived with nothing in flight.

Function
REQ-017 States IDLE and BUSY; a packet holds the grant from first beat through req_last.
REQ-018 IDLE: if any req_valid and in-flight count < MAX_OUT, register grant to first valid requester searching upward from rr_ptr modulo NUM_REQ, go BUSY next cycle.
REQ-019 IDLE: req_ready all zero; no beat accepted in the arbitration cycle.
REQ-020 BUSY: req_ready[g] = (in-flight count < MAX_OUT), all other req_ready zero.
REQ-021 Beat accepted when req_valid[g] & req_ready[g]; data_rt_in and data_in_rt_valid registered, asserted exactly one cycle after acceptance for one cycle.
REQ-022 Each accepted beat pushes g into an in-order tag FIFO of depth MAX_OUT; in-flight count equals FIFO occupancy.
REQ-023 Acceptance of beat with req_last[g]=1: go IDLE, rr_ptr = (g+1) mod NUM_REQ.
REQ-024 Deasserted req_valid[g] in BUSY holds grant (no timeout).
REQ-025 data_out_rt_valid with FIFO non-empty: pop tag t; next cycle rsp_valid = one-hot(t), rsp_data = data_rt_out, one cycle.
REQ-026 data_out_rt_valid with FIFO empty: result dropped, rsp_valid stays zero, err_unexpected set until reset.
REQ-027 Same-cycle push and pop: count unchanged, both take effect; push with count==MAX_OUT impossible since req_ready low.
REQ-028 Count at MAX_OUT: req_ready low until a pop; pop in same cycle does not raise req_ready that cycle (ready uses registered count).
REQ-029 Idle data_rt_in and rsp_data hold last value; only strobes are qualifiers.

Reset
REQ-030 Reset: state IDLE, rr_ptr 0, grant 0, FIFO empty, count 0, err_unexpected 0, all strobes and req_ready 0, data outputs 0.
REQ-031 Reset mid-packet or with beats in flight discards all tags; later results count as unexpected.

Structure
REQ-032 Package router_arb_pkg holds NUM_REQ, WIDTH, MAX_OUT defaults, tag width $clog2(NUM_REQ), and state enum {IDLE, BUSY}.
REQ-033 Sub-module tag_fifo (depth MAX_OUT, width tag, push/pop/count/empty/full, pointer wrap) instantiated once.

Verification
REQ-034 Req1 sends 3 beats 0xA1,0xA2,0xA3 (last on third), datapath echoes +1 after 2 cycles -> data_in_rt_valid 3 cycles, rsp_valid=0b0010 with 0xA2,0xA3,0xA4 in order.
REQ-035 All four requesters hold single-beat packets continuously -> grants 0,1,2,3,0 in order; no requester granted twice before others.
REQ-036 Datapath withholds results, req0 streams 10 beats -> exactly 8 accepted, req_ready0 low; one result returns -> ready high next cycle, 9th beat accepted.
REQ-037 data_out_rt_valid pulse after reset with nothing sent -> rsp_valid stays 0, err_unexpected 1 and stays 1.
REQ-038 Reset asserted with 3 beats in flight mid-packet -> all outputs 0 next cycle, state IDLE, 3 returning results each keep rsp_valid 0 and set err_unexpected.
REQ-039 Push and pop in same cycle at count 4 -> count remains 4, response routed to oldest tag.
